// File: rtl/uart_tx_result_if.sv
// uart_tx_result_if: request/status bundle between the ALU result path and the UART transmitter.
//   tick     - 16x baud oversampling strobe (driver -> transmitter)
//   tx_start - request to send data (driver -> transmitter)
//   data     - word to transmit (driver -> transmitter)
//   tx       - serial line, idle high (transmitter -> driver)
//   busy     - frame in progress (transmitter -> driver)
//   tx_done  - one-clock end-of-frame pulse (transmitter -> driver)
interface uart_tx_result_if #(parameter int NB_DATA = 8);
    logic               tick;
    logic               tx_start;
    logic [NB_DATA-1:0] data;
    logic               tx;
    logic               busy;
    logic               tx_done;
    modport master (output tick, tx_start, data, input tx, busy, tx_done);
    modport slave  (input tick, tx_start, data, output tx, busy, tx_done);
endinterface

// File: rtl/uart_tx_result.sv
// uart_tx_result: serializes an NB_DATA-bit word into a start/data/stop asynchronous frame, LSB first.
//   i_clk   - system clock, rising edge
//   i_reset - asynchronous active-high reset
//   bus     - slave side of uart_tx_result_if (tick, tx_start, data in; tx, busy, tx_done out)
module uart_tx_result #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_tx_result_if.slave bus
);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(NB_DATA);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t             state, state_n;
    logic [SW-1:0]      s, s_n;
    logic [NW-1:0]      n, n_n;
    logic [NB_DATA-1:0] b, b_n;
    logic               tx_r, tx_n;
    logic               done_r, done_n;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            tx_r   <= 1'b1;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            b      <= b_n;
            tx_r   <= tx_n;
            done_r <= done_n;
        end
    end
    // The tx line is registered one step ahead: each transition also loads the level of the next bit.
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        tx_n    = tx_r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (bus.tx_start) begin
                    b_n     = bus.data;
                    s_n     = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bus.tick) begin
                    if (s == SW'(15)) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = DATA;
                        tx_n    = b[0];
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_n = b[0];
                if (bus.tick) begin
                    if (s == SW'(15)) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == NW'(NB_DATA - 1)) begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end else begin
                            n_n  = n + 1'b1;
                            tx_n = b[1];
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: begin
                tx_n = 1'b1;
                if (bus.tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        state_n = IDLE;
                        s_n     = '0;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
        endcase
    end
    assign bus.tx      = tx_r;
    assign bus.busy    = (state != IDLE);
    assign bus.tx_done = done_r;
endmodule
